// File: rtl/clk_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_pkg
// Description : Shared constants and types for the multi-channel clock
//               divider. Half-period terminal counts assume a 12 MHz clock.
// Revision    : 1.0 - initial release
// ============================================================================
package clk_div_pkg;

    // Half-period terminal counts at 12 MHz (half period = value + 1 cycles)
    localparam int unsigned c_HALF_1HZ   = 5999999;
    localparam int unsigned c_HALF_10HZ  = 599999;
    localparam int unsigned c_HALF_1KHZ  = 5999;

    // Default geometry
    localparam int unsigned c_DEF_CHANNELS = 4;
    localparam int unsigned c_DEF_WIDTH    = 21;

    // What a channel does on the coming edge, in priority order
    typedef enum logic [1:0] {
        ACT_RESTART = 2'd0,   // disabled or phase-aligned: back to start of low half
        ACT_TOGGLE  = 2'd1,   // terminal count reached: flip clk_out
        ACT_COUNT   = 2'd2    // keep counting inside the current half
    } chan_act_e;

    // Width of the channel select; never narrower than one bit so a
    // single-channel build still has a usable (and out-of-range-capable) select
    function automatic int unsigned cw_of(input int unsigned channels);
        return (channels <= 1) ? 1 : $clog2(channels);
    endfunction

endpackage : clk_div_pkg
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_chan
// Description : One divider channel. Counts up to the active half-period
//               terminal, toggles clk_out there and strobes tick on the rising
//               toggle. New rates are held in a shadow register and only
//               copied into the active terminal at a half-period boundary,
//               which keeps every output half period whole.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int unsigned WIDTH      = c_DEF_WIDTH,
    parameter int unsigned RESET_HALF = c_HALF_10HZ
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sync_i,
    input  logic             load_i,       // config transfer addressed to this channel
    input  logic [WIDTH-1:0] load_half_i,
    output logic             pend_o,       // a shadow value is waiting to be applied
    output logic             clk_out_o,
    output logic             tick_o
);

    localparam logic [WIDTH-1:0] c_RESET_HALF = WIDTH'(RESET_HALF);

    logic [WIDTH-1:0] cnt_q,       cnt_d;
    logic [WIDTH-1:0] half_q,      half_d;
    logic [WIDTH-1:0] pend_half_q, pend_half_d;
    logic             pend_q,      pend_d;
    logic             clk_q,       clk_d;
    logic             tick_q,      tick_d;

    chan_act_e        w_act;

    // Select this edge's action; enable and sync outrank the terminal count
    always_comb begin
        w_act = ACT_COUNT;
        if (!en_i || sync_i) begin
            w_act = ACT_RESTART;
        end else if (cnt_q == half_q) begin
            w_act = ACT_TOGGLE;
        end
    end

    // Next-state for counter, outputs and the active/shadow terminal counts
    always_comb begin
        cnt_d       = cnt_q;
        half_d      = half_q;
        pend_half_d = pend_half_q;
        pend_d      = pend_q;
        clk_d       = clk_q;
        tick_d      = 1'b0;

        case (w_act)
            ACT_RESTART: begin
                cnt_d = '0;
                clk_d = 1'b0;
            end
            ACT_TOGGLE: begin
                cnt_d  = '0;
                clk_d  = ~clk_q;
                // Only the low-to-high toggle produces a tick
                tick_d = ~clk_q;
            end
            default: begin
                // Terminal compare stops the count at half_q, so no wrap
                cnt_d = cnt_q + WIDTH'(1);
            end
        endcase

        // Every non-counting edge is a half-period boundary: safe to swap rates
        if ((w_act != ACT_COUNT) && pend_q) begin
            half_d = pend_half_q;
            pend_d = 1'b0;
        end

        // A transfer only arrives while pend_q is clear, so it never collides
        // with the apply above. An idle channel takes the rate immediately;
        // a running one parks it until the next boundary.
        if (load_i) begin
            if (!en_i) begin
                half_d = load_half_i;
            end else begin
                pend_half_d = load_half_i;
                pend_d      = 1'b1;
            end
        end
    end

    // Channel state registers with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q       <= '0;
            half_q      <= c_RESET_HALF;
            pend_half_q <= c_RESET_HALF;
            pend_q      <= 1'b0;
            clk_q       <= 1'b0;
            tick_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            half_q      <= half_d;
            pend_half_q <= pend_half_d;
            pend_q      <= pend_d;
            clk_q       <= clk_d;
            tick_q      <= tick_d;
        end
    end

    assign pend_o    = pend_q;
    assign clk_out_o = clk_q;
    assign tick_o    = tick_q;

endmodule : clk_div_chan
`default_nettype wire

// File: rtl/clk_div_multi.sv
`default_nettype none
// ============================================================================
// Module      : clk_div_multi
// Description : Programmable multi-channel clock divider / tick generator.
//               Holds the configuration decode and ready mux; each channel
//               is an independent clk_div_chan instance sharing sync.
// Revision    : 1.0 - initial release
// ============================================================================
module clk_div_multi
    import clk_div_pkg::*;
#(
    parameter int unsigned CHANNELS   = c_DEF_CHANNELS,
    parameter int unsigned WIDTH      = c_DEF_WIDTH,
    parameter int unsigned RESET_HALF = c_HALF_10HZ,
    localparam int unsigned CW        = cw_of(CHANNELS)
) (
    input  logic                clk_in,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CW-1:0]       cfg_chan,
    input  logic [WIDTH-1:0]    cfg_half,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    logic [CHANNELS-1:0] w_pend;
    logic [CHANNELS-1:0] w_load;

    // Ready mux: busy only while the addressed channel still holds a shadow
    // value; selects that match no channel are always accepted and dropped
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (cfg_chan == CW'(i)) begin
                cfg_ready = ~w_pend[i];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
            // Transfer strobe for this channel
            assign w_load[gi] = cfg_valid & cfg_ready & (cfg_chan == CW'(gi));

            clk_div_chan #(
                .WIDTH      (WIDTH),
                .RESET_HALF (RESET_HALF)
            ) u_chan (
                .clk_i       (clk_in),
                .rst_ni      (rst_n),
                .en_i        (en[gi]),
                .sync_i      (sync),
                .load_i      (w_load[gi]),
                .load_half_i (cfg_half),
                .pend_o      (w_pend[gi]),
                .clk_out_o   (clk_out[gi]),
                .tick_o      (tick[gi])
            );
        end
    endgenerate

endmodule : clk_div_multi
`default_nettype wire
